// File: rtl/bio_arb.sv
// bio_arb: two-master round-robin arbiter in front of the bio slave.
// Master 0 is the CPU bus port, master 1 the debug/monitor port. One transaction per grant,
// with one forced idle cycle between grants.
// Optional slave-ack watchdog enabled by defining BIO_ARB_TIMEOUT_EN.
module bio_arb #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // master 0 (CPU bus)
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic        m0_addr,
    input  logic [31:0] m0_data_in,
    output logic [31:0] m0_data_out,
    output logic        m0_ack,
    output logic        m0_err,
    // master 1 (debug/monitor)
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic        m1_addr,
    input  logic [31:0] m1_data_in,
    output logic [31:0] m1_data_out,
    output logic        m1_ack,
    output logic        m1_err,
    // bio slave
    output logic        s_stb,
    output logic        s_we,
    output logic        s_addr,
    output logic [31:0] s_data_out,
    input  logic [31:0] s_data_in,
    input  logic        s_ack
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e state_q;
    logic   last_q;     // master served most recently; reset to 1 so master 0 wins first

    logic   granted;
    logic   sel_m1;
    logic   gnt_stb;
    logic   timeout;
    logic   done;

`ifdef BIO_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;

    // Watchdog: cleared while idle so it starts at 0 on grant entry, counts ack-less grant cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (state_q == StIdle) begin
            cnt_q <= 8'd0;
        end else if (!s_ack) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Expiry only when the slave stays silent; a same-cycle s_ack takes precedence
    always_comb begin
        timeout = granted && gnt_stb && !s_ack && (cnt_q == 8'(TO_CYCLES - 1));
    end
`else
    logic [7:0] unused_to_cycles;
    assign unused_to_cycles = 8'(TO_CYCLES);

    // No watchdog: a grant is held until ack or strobe drop
    always_comb begin
        timeout = 1'b0;
    end
`endif

    // Decode the current grant and its completion condition
    always_comb begin
        granted = (state_q != StIdle);
        sel_m1  = (state_q == StGnt1);
        gnt_stb = sel_m1 ? m1_stb : m0_stb;
        done    = granted && gnt_stb && (s_ack || timeout);
    end

    // Forward the granted master to the slave; everything else reads as zero
    always_comb begin
        s_stb       = 1'b0;
        s_we        = 1'b0;
        s_addr      = 1'b0;
        s_data_out  = 32'd0;
        m0_data_out = 32'd0;
        m0_ack      = 1'b0;
        m0_err      = 1'b0;
        m1_data_out = 32'd0;
        m1_ack      = 1'b0;
        m1_err      = 1'b0;
        if (granted) begin
            s_stb      = gnt_stb;
            s_we       = sel_m1 ? m1_we : m0_we;
            s_addr     = sel_m1 ? m1_addr : m0_addr;
            s_data_out = sel_m1 ? m1_data_in : m0_data_in;
            if (sel_m1) begin
                m1_ack      = done;
                m1_err      = timeout;
                m1_data_out = timeout ? 32'd0 : s_data_in;
            end else begin
                m0_ack      = done;
                m0_err      = timeout;
                m0_data_out = timeout ? 32'd0 : s_data_in;
            end
        end
    end

    // Arbitration FSM: round-robin on conflict, return to idle after every transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m0_stb && m1_stb) begin
                        state_q <= last_q ? StGnt0 : StGnt1;
                    end else if (m0_stb) begin
                        state_q <= StGnt0;
                    end else if (m1_stb) begin
                        state_q <= StGnt1;
                    end
                end
                StGnt0, StGnt1: begin
                    // Strobe drop without ack is a protocol violation: abandon silently
                    if (!gnt_stb || done) begin
                        state_q <= StIdle;
                        last_q  <= sel_m1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bio_arb.sv
// Self-checking bench for bio_arb: directed scenarios plus a randomized run against a
// transaction-level model (owner / last-served / wait-count).
module tb_bio_arb;

    localparam int TO = 4;
`ifdef BIO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_stb, m0_we, m0_addr;
    logic [31:0] m0_data_in, m0_data_out;
    logic        m0_ack, m0_err;
    logic        m1_stb, m1_we, m1_addr;
    logic [31:0] m1_data_in, m1_data_out;
    logic        m1_ack, m1_err;
    logic        s_stb, s_we, s_addr;
    logic [31:0] s_data_out, s_data_in;
    logic        s_ack;
    logic        ack_follow, ack_manual;

    int checks = 0;
    int failures = 0;

    // Zero-wait slave when ack_follow is set, otherwise a bench-driven ack
    assign s_ack = ack_follow ? s_stb : ack_manual;

    always #5 clk = ~clk;

    bio_arb #(.TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_in(m0_data_in),
        .m0_data_out(m0_data_out), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_in(m1_data_in),
        .m1_data_out(m1_data_out), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_data_out(s_data_out),
        .s_data_in(s_data_in), .s_ack(s_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_stb = 0; m0_we = 0; m0_addr = 0; m0_data_in = 0;
        m1_stb = 0; m1_we = 0; m1_addr = 0; m1_data_in = 0;
        s_data_in = 0; ack_follow = 0; ack_manual = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_stb = 1; m1_stb = 1; m0_data_in = 32'hFFFF_FFFF; m1_data_in = 32'hFFFF_FFFF;
        s_data_in = 32'hDEAD_BEEF; ack_manual = 1;
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({s_stb, s_we, s_addr, s_data_out, m0_ack, m0_err, m0_data_out,
                 m1_ack, m1_err, m1_data_out} !== 103'd0) begin
                failures++;
                $display("FAIL reset_outputs: s_stb=%b m0_ack=%b m1_ack=%b s_data_out=%h want all 0",
                         s_stb, m0_ack, m1_ack, s_data_out);
            end
        end
        clear_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        ack_follow = 1;
        m0_stb = 1; m0_we = 1; m0_addr = 0; m0_data_in = 32'hA5A5_0001;
        #1;
        checks++;
        if (s_stb !== 1'b0) begin
            failures++; $display("FAIL write_c0_idle: s_stb=%b want 0", s_stb);
        end
        tick();  // cycle 1
        checks++;
        if ({s_stb, s_we, s_data_out, m0_ack, m1_ack} !== {1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL write_c1: s_stb=%b s_we=%b s_data_out=%h m0_ack=%b m1_ack=%b want 1 1 a5a50001 1 0",
                     s_stb, s_we, s_data_out, m0_ack, m1_ack);
        end
        tick();  // cycle 2: back in idle even though m0 still requests
        checks++;
        if ({s_stb, m0_ack, m1_ack, s_data_out} !== 35'd0) begin
            failures++;
            $display("FAIL write_c2_idle: s_stb=%b m0_ack=%b m1_ack=%b s_data_out=%h want 0",
                     s_stb, m0_ack, m1_ack, s_data_out);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        do_reset();
        ack_follow = 1;
        m0_stb = 1; m1_stb = 1;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            #1;
            if (c % 2 == 0) want = 2'b00;
            else if (c % 4 == 1) want = 2'b01;
            else want = 2'b10;
            checks++;
            if ({m1_ack, m0_ack} !== want) begin
                failures++;
                $display("FAIL alternate_c%0d: {m1_ack,m0_ack}=%b want %b", c, {m1_ack, m0_ack}, want);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_read_m1();
        ack_follow = 1;
        m1_stb = 1; m1_we = 0; m1_addr = 1; s_data_in = 32'h0000_0021;
        #1;
        checks++;
        if (m0_data_out !== 32'd0 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL read_c0: m0_data_out=%h m1_ack=%b want 0 0", m0_data_out, m1_ack);
        end
        tick();
        checks++;
        if ({m1_data_out, m1_ack, s_addr, s_we, m0_data_out} !== {32'h21, 1'b1, 1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL read_c1: m1_data_out=%h m1_ack=%b s_addr=%b s_we=%b m0_data_out=%h want 21 1 1 0 0",
                     m1_data_out, m1_ack, s_addr, s_we, m0_data_out);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_stb = 1; m0_data_in = 32'h1234_5678; s_data_in = 32'hCAFE_0000;
        if (TO_EN) begin
            for (int c = 1; c <= TO; c++) begin
                tick();
                checks++;
                if ({m0_ack, m0_err, s_stb} !== ((c == TO) ? 3'b111 : 3'b001) ||
                    (c == TO && m0_data_out !== 32'd0)) begin
                    failures++;
                    $display("FAIL timeout_c%0d: m0_ack=%b m0_err=%b s_stb=%b m0_data_out=%h",
                             c, m0_ack, m0_err, s_stb, m0_data_out);
                end
            end
            m0_stb = 0; m1_stb = 1;
            tick();  // idle after expiry
            tick();  // next grant goes to m1
            checks++;
            if (s_stb !== 1'b1 || m0_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_next_grant: s_stb=%b m0_err=%b want 1 0", s_stb, m0_err);
            end
        end else begin
            for (int c = 1; c <= 20; c++) begin
                tick();
                checks++;
                if ({m0_ack, m0_err, s_stb} !== 3'b001) begin
                    failures++;
                    $display("FAIL no_timeout_c%0d: m0_ack=%b m0_err=%b s_stb=%b want 0 0 1",
                             c, m0_ack, m0_err, s_stb);
                end
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_stb = 1;
        tick();  // GNT1
        #1;
        checks++;
        if (s_stb !== 1'b1) begin
            failures++; $display("FAIL midreset_gnt1: s_stb=%b want 1", s_stb);
        end
        rst_n = 0; ack_manual = 1;
        #1;
        checks++;
        if (s_stb !== 1'b0 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: s_stb=%b m1_ack=%b want 0 0", s_stb, m1_ack);
        end
        m0_stb = 1;
        @(posedge clk);
        #3;
        rst_n = 1; ack_manual = 0; ack_follow = 1;
        tick();
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_first_m0: m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stb_drop();
        do_reset();
        m0_stb = 1; m1_stb = 1;
        tick();  // GNT0, slave silent
        m0_stb = 0;
        #1;
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            failures++;
            $display("FAIL drop_c1: s_stb=%b m0_ack=%b m1_ack=%b want 0 0 0", s_stb, m0_ack, m1_ack);
        end
        ack_manual = 1;
        tick();  // idle: stray s_ack ignored
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            failures++;
            $display("FAIL drop_c2_idle: s_stb=%b m0_ack=%b m1_ack=%b want 0 0 0", s_stb, m0_ack, m1_ack);
        end
        tick();  // m1 granted
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b101) begin
            failures++;
            $display("FAIL drop_c3_m1: s_stb=%b m0_ack=%b m1_ack=%b want 1 0 1", s_stb, m0_ack, m1_ack);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int          owner;   // -1 idle, else granted master
        int          last;
        int          waited;  // ack-less cycles spent in the current grant
        logic        stb [2];
        logic        we [2];
        logic        addr [2];
        logic [31:0] din [2];
        logic [31:0] dout [2];
        logic        ack [2];
        logic        err [2];
        logic        e_stb, e_we, e_addr, expired, fin;
        logic [31:0] e_sdo;
        logic [102:0] got, exp;
        do_reset();
        owner = -1; last = 1; waited = 0;
        for (int n = 0; n < 400; n++) begin
            m0_stb = ($urandom_range(0, 3) != 0);
            m1_stb = ($urandom_range(0, 3) != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_addr = 1'($urandom); m1_addr = 1'($urandom);
            m0_data_in = $urandom; m1_data_in = $urandom; s_data_in = $urandom;
            ack_manual = ($urandom_range(0, 2) == 0);
            #1;
            stb[0] = m0_stb; stb[1] = m1_stb; we[0] = m0_we; we[1] = m1_we;
            addr[0] = m0_addr; addr[1] = m1_addr; din[0] = m0_data_in; din[1] = m1_data_in;
            for (int i = 0; i < 2; i++) begin
                dout[i] = 0; ack[i] = 0; err[i] = 0;
            end
            e_stb = 0; e_we = 0; e_addr = 0; e_sdo = 0; expired = 0; fin = 0;
            if (owner >= 0) begin
                e_stb = stb[owner]; e_we = we[owner]; e_addr = addr[owner]; e_sdo = din[owner];
                expired = TO_EN && stb[owner] && !ack_manual && (waited == TO - 1);
                fin = stb[owner] && (ack_manual || expired);
                ack[owner] = fin;
                err[owner] = expired;
                dout[owner] = expired ? 32'd0 : s_data_in;
            end
            exp = {e_stb, e_we, e_addr, e_sdo, ack[0], err[0], dout[0], ack[1], err[1], dout[1]};
            got = {s_stb, s_we, s_addr, s_data_out, m0_ack, m0_err, m0_data_out,
                   m1_ack, m1_err, m1_data_out};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random_n%0d: outputs=%h want %h (owner=%0d)", n, got, exp, owner);
            end
            tick();
            if (owner < 0) begin
                if (stb[0] && stb[1]) owner = (last == 0) ? 1 : 0;
                else if (stb[0]) owner = 0;
                else if (stb[1]) owner = 1;
                waited = 0;
            end else if (!stb[owner] || fin) begin
                last = owner;
                owner = -1;
            end else if (!ack_manual) begin
                waited++;
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_single_write();
        test_alternate();
        test_read_m1();
        test_timeout();
        test_reset_mid();
        test_stb_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
